// File: rtl/adc_pkg.sv
// Shared flash-ADC constants and Gray helpers used by the encoder and the decoder.
// Pure package: no state and no flow control.
package adc_pkg;

    localparam int GW = 5;
    localparam int TW = 2**GW;

    typedef struct packed {
        logic [GW-1:0] g;
        logic          ovr;
        logic          err;
    } res_t;

    function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
        logic [GW-1:0] b;
        b[GW-1] = g[GW-1];
        for (int i = GW-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/bubble_fix_tw.sv
// Three-input majority vote across a thermometer word, edges padded with 1 below and 0 above.
// Combinational, zero latency, no flow control.
module bubble_fix_tw #(
    parameter int TW = 32
) (
    input  logic [TW-1:0] i_t,
    output logic [TW-1:0] o_c
);

    logic [TW+1:0] w_ext;

    assign w_ext = {1'b0, i_t, 1'b1};

    for (genvar i = 0; i < TW; i++) begin : g_vote
        assign o_c[i] = (w_ext[i]   & w_ext[i+1]) |
                        (w_ext[i]   & w_ext[i+2]) |
                        (w_ext[i+1] & w_ext[i+2]);
    end

endmodule

// File: rtl/enc_therm32_gray5.sv
// Thermometer-to-Gray encoder: capture, bubble-correct, then popcount/saturate/Gray.
// Result two edges after capture; accepts a sample every cycle, never stalls.
module enc_therm32_gray5
    import adc_pkg::*;
#(
    parameter int TW = adc_pkg::TW,
    parameter int GW = adc_pkg::GW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [TW-1:0] T,
    output logic          out_valid,
    output logic [GW-1:0] G,
    output logic          ovr,
    output logic          err
);

    logic          r_s1_vld;
    logic [TW-1:0] r_s1_t;
    logic          r_s2_vld;
    logic [TW-1:0] r_s2_c;
    logic          r_s3_vld;
    res_t          r_s3;

    logic [TW-1:0] w_c;
    logic [GW-1:0] w_cnt;
    logic [GW-1:0] w_n;
    logic          w_ovr;
    logic          w_err;

    bubble_fix_tw #(
        .TW (TW)
    ) u_bubble_fix (
        .i_t (r_s1_t),
        .o_c (w_c)
    );

    // Ones-count over the lower TW-1 bits tolerates leftover bubbles better than edge search.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < TW-1; i++) begin
            w_cnt = w_cnt + {{(GW-1){1'b0}}, r_s2_c[i]};
        end
    end

    assign w_ovr = r_s2_c[TW-1];
    assign w_n   = w_ovr ? '1 : w_cnt;
    assign w_err = |(~r_s2_c[TW-2:0] & r_s2_c[TW-1:1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s1_t   <= '0;
            r_s2_vld <= 1'b0;
            r_s2_c   <= '0;
            r_s3_vld <= 1'b0;
            r_s3     <= '0;
        end else begin
            r_s1_vld <= in_valid;
            if (in_valid) begin
                r_s1_t <= T;
            end
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_c <= w_c;
            end
            r_s3_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_s3.g   <= bin2gray(w_n);
                r_s3.ovr <= w_ovr;
                r_s3.err <= w_err;
            end
        end
    end

    assign out_valid = r_s3_vld;
    assign G         = r_s3.g;
    assign ovr       = r_s3.ovr;
    assign err       = r_s3.err;

endmodule

// File: tb/tb_enc_therm32_gray5.sv
// Scoreboarded bench for the thermometer-to-Gray encoder.
module tb_enc_therm32_gray5;

    typedef struct packed {
        logic [4:0] g;
        logic       ovr;
        logic       err;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] T;
    logic        out_valid;
    logic [4:0]  G;
    logic        ovr;
    logic        err;

    res_t exp_q[$];
    res_t obs_q[$];
    int   obs_cyc[$];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    int   cyc      = 0;
    int   hold_bad = 0;
    logic had_out  = 1'b0;
    res_t last_res;
    res_t mon_cur;
    res_t mon_exp;

    enc_therm32_gray5 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .T         (T),
        .out_valid (out_valid),
        .G         (G),
        .ovr       (ovr),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [31:0] t);
        logic [31:0] c;
        logic        lo;
        logic        hi;
        int          n;
        logic [4:0]  b;
        res_t        r;
        for (int i = 0; i < 32; i++) begin
            lo = 1'b1;
            hi = 1'b0;
            if (i > 0)  lo = t[i-1];
            if (i < 31) hi = t[i+1];
            c[i] = (lo && t[i]) || (lo && hi) || (t[i] && hi);
        end
        n = 0;
        for (int i = 0; i < 31; i++) n += int'(c[i]);
        r.ovr = c[31];
        if (c[31]) n = 31;
        r.err = 1'b0;
        for (int i = 0; i < 31; i++) if (!c[i] && c[i+1]) r.err = 1'b1;
        b   = n[4:0];
        r.g = b ^ {1'b0, b[4:1]};
        return r;
    endfunction

    always @(negedge clk) begin
        mon_cur = {G, ovr, err};
        if (rst) begin
            had_out = 1'b0;
        end else if (out_valid) begin
            n_out++;
            obs_q.push_back(mon_cur);
            obs_cyc.push_back(cyc);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: out_valid=1 G=%b ovr=%b err=%b, want no output", G, ovr, err);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_cur !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_result: got G=%b ovr=%b err=%b, want G=%b ovr=%b err=%b",
                             G, ovr, err, mon_exp.g, mon_exp.ovr, mon_exp.err);
                end
            end
            had_out  = 1'b1;
            last_res = mon_cur;
        end else if (had_out && mon_cur !== last_res) begin
            hold_bad++;
        end
    end

    task automatic drive(input logic v, input logic [31:0] t);
        @(posedge clk);
        #1;
        in_valid = v;
        T        = t;
        if (v) exp_q.push_back(model(t));
    endtask

    task automatic wait_drain(output bit ok);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(negedge clk);
            w++;
        end
        #1;
        ok = (exp_q.size() == 0);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        T        = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out_valid, G, ovr, err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_state: got ov=%b G=%b ovr=%b err=%b, want all zero", out_valid, G, ovr, err);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        T        = '0;
    endtask

    task automatic test_latency();
        drive(1'b1, 32'h0000_0003);
        drive(1'b0, 32'h0);
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL latency_early: out_valid=%b, want 0", out_valid);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, G, ovr, err} !== {1'b1, 5'b00011, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL latency_k2: got ov=%b G=%b ovr=%b err=%b, want ov=1 G=00011 ovr=0 err=0",
                     out_valid, G, ovr, err);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, G} !== {1'b0, 5'b00011}) begin
            n_fail++;
            $display("FAIL latency_after: got ov=%b G=%b, want ov=0 G=00011", out_valid, G);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] sweep_t [32];
        logic [4:0]  b;
        logic [31:0] th;
        bit          ok;
        obs_q.delete();
        obs_cyc.delete();
        for (int n = 0; n < 32; n++) begin
            sweep_t[n] = (n == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - n));
            drive(1'b1, sweep_t[n]);
        end
        drive(1'b0, 32'h0);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != 32) begin
            n_fail++;
            $display("FAIL sweep_count: got %0d results (pending %0d), want 32", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 32; i++) begin
            b[4] = obs_q[i].g[4];
            for (int j = 3; j >= 0; j--) b[j] = b[j+1] ^ obs_q[i].g[j];
            th = '0;
            for (int j = 0; j < 32; j++) if (j < int'(b)) th[j] = 1'b1;
            n_checks++;
            if (th !== sweep_t[i] || obs_q[i].err !== 1'b0 || obs_q[i].ovr !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_roundtrip[%0d]: G=%b decodes to %h ovr=%b err=%b, want %h ovr=0 err=0",
                         i, obs_q[i].g, th, obs_q[i].ovr, obs_q[i].err, sweep_t[i]);
            end
            if (i > 0) begin
                n_checks++;
                if (obs_cyc[i] - obs_cyc[i-1] != 1) begin
                    n_fail++;
                    $display("FAIL sweep_throughput[%0d]: gap %0d cycles, want 1", i, obs_cyc[i] - obs_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_bubble_ovr();
        bit   ok;
        res_t want [4];
        want[0] = {5'b01100, 1'b0, 1'b0};
        want[1] = {5'b10000, 1'b1, 1'b0};
        want[2] = {5'b00110, 1'b0, 1'b1};
        want[3] = {5'b10000, 1'b0, 1'b0};
        obs_q.delete();
        obs_cyc.delete();
        drive(1'b1, 32'h0000_00FB);
        drive(1'b1, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_00F0);
        drive(1'b1, 32'hBFFF_FFFF);
        drive(1'b0, 32'h0);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != 4) begin
            n_fail++;
            $display("FAIL bubble_count: got %0d results, want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 4; i++) begin
            n_checks++;
            if (obs_q[i] !== want[i]) begin
                n_fail++;
                $display("FAIL bubble_case[%0d]: got G=%b ovr=%b err=%b, want G=%b ovr=%b err=%b",
                         i, obs_q[i].g, obs_q[i].ovr, obs_q[i].err, want[i].g, want[i].ovr, want[i].err);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, $urandom());
        end
        drive(1'b0, 32'h0);
        wait_drain(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL random_drain: %0d results pending, want 0", exp_q.size());
        end
    endtask

    task automatic test_toggle();
        bit ok;
        obs_q.delete();
        obs_cyc.delete();
        hold_bad = 0;
        drive(1'b1, 32'h0000_0003);
        drive(1'b0, 32'h0);
        drive(1'b1, 32'h0000_00FF);
        drive(1'b0, 32'h0);
        wait_drain(ok);
        n_checks++;
        if (!ok || obs_q.size() != 2) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d results, want 2", obs_q.size());
        end else begin
            n_checks++;
            if (obs_cyc[1] - obs_cyc[0] != 2) begin
                n_fail++;
                $display("FAIL toggle_pattern: outputs %0d cycles apart, want 2", obs_cyc[1] - obs_cyc[0]);
            end
            n_checks++;
            if (obs_q[0].g !== 5'b00011 || obs_q[1].g !== 5'b01100) begin
                n_fail++;
                $display("FAIL toggle_values: got G=%b,%b, want 00011,01100", obs_q[0].g, obs_q[1].g);
            end
        end
        n_checks++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("FAIL toggle_hold: %0d gap cycles changed outputs, want 0", hold_bad);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        drive(1'b1, 32'hFFFF_FFFF);
        drive(1'b1, 32'h0000_0001);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if ({out_valid, G, ovr, err} !== 8'b0) begin
            n_fail++;
            $display("FAIL midreset_async: got ov=%b G=%b ovr=%b err=%b, want all zero", out_valid, G, ovr, err);
        end
        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = n_out;
        repeat (8) @(negedge clk);
        n_checks++;
        if (n_out != base || {out_valid, G} !== 6'b0) begin
            n_fail++;
            $display("FAIL midreset_flush: got %0d results after release ov=%b G=%b, want 0 results, zero outputs",
                     n_out - base, out_valid, G);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_sweep();
        test_bubble_ovr();
        test_random();
        test_toggle();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
